// File: rtl/eth_frame_gen_pkg.sv
// eth_frame_gen_pkg
// Shared types and constants for the Ethernet test-frame generator.
//   state_t  : generator FSM states (IDLE, SEND, WAIT)
//   OFF_*    : byte offsets of the header fields inside a generated frame
//   HDR_LEN  : number of fixed header bytes ahead of the sequence number
package eth_frame_gen_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    localparam int unsigned OFF_SRC  = 6;
    localparam int unsigned OFF_TYPE = 12;
    localparam int unsigned OFF_SEQ  = 14;
    localparam int unsigned OFF_PAT  = 18;
    localparam int unsigned HDR_LEN  = OFF_SEQ;

endpackage

// File: rtl/eth_frame_gen.sv
// eth_frame_gen
// Periodic AXI-Stream Ethernet test-frame source for the MAC tx_axis input.
// Each frame: destination MAC, source MAC, EtherType, 32-bit big-endian
// sequence number, then an incrementing byte pattern. The MAC appends
// preamble, padding and FCS.
//
// Ports:
//   clk            : single clock
//   rst_n          : synchronous active-low reset
//   enable         : level, allows new frames to start
//   m_axis_tdata   : frame byte (registered)
//   m_axis_tvalid  : beat valid (registered, independent of tready)
//   m_axis_tready  : sink ready
//   m_axis_tlast   : last byte of frame
//   m_axis_tuser   : constant 0
//   frame_count    : completed frames, wraps (mirrors the sequence number)
//   busy           : high while a frame is being sent
module eth_frame_gen
    import eth_frame_gen_pkg::*;
#(
    parameter logic [47:0] DST_MAC     = 48'hFFFF_FFFF_FFFF,
    parameter logic [47:0] SRC_MAC     = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETHERTYPE   = 16'h88B5,
    parameter int unsigned PAYLOAD_LEN = 46,
    parameter int unsigned INTERVAL    = 125_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    output logic [31:0] frame_count,
    output logic        busy
);

    localparam int unsigned N  = HDR_LEN + PAYLOAD_LEN;
    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(INTERVAL - 1);

    state_t        state;
    logic [IW-1:0] i;
    logic [IW-1:0] i_nxt;
    logic [31:0]   seq;
    logic [CW-1:0] cnt;

    assign i_nxt        = i + 1'b1;
    assign m_axis_tuser = 1'b0;
    assign frame_count  = seq;

    // Byte value at frame index idx for sequence number s. Header fields are
    // extracted by shifting so the field is sent most significant byte first.
    function automatic logic [7:0] byte_at(input logic [IW-1:0] idx,
                                           input logic [31:0]   s);
        int unsigned k;
        logic [47:0] sh;
        logic [7:0]  b;
        k  = 32'(idx);
        sh = '0;
        b  = '0;
        if (k < OFF_SRC) begin
            sh = DST_MAC >> (8 * (OFF_SRC - 1 - k));
            b  = sh[7:0];
        end else if (k < OFF_TYPE) begin
            sh = SRC_MAC >> (8 * (OFF_TYPE - 1 - k));
            b  = sh[7:0];
        end else if (k < OFF_SEQ) begin
            sh = 48'(ETHERTYPE >> (8 * (OFF_SEQ - 1 - k)));
            b  = sh[7:0];
        end else if (k < OFF_PAT) begin
            sh = 48'(s >> (8 * (OFF_PAT - 1 - k)));
            b  = sh[7:0];
        end else begin
            // pattern byte is (k - OFF_PAT) mod 256: truncation does the mod
            b = 8'(k - OFF_PAT);
        end
        return b;
    endfunction

    // tdata is loaded one index ahead on every handshake so the output is a
    // plain register and never sees tready combinationally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            i             <= '0;
            seq           <= '0;
            cnt           <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state         <= SEND;
                        i             <= '0;
                        m_axis_tvalid <= 1'b1;
                        m_axis_tlast  <= 1'b0;
                        m_axis_tdata  <= byte_at('0, seq);
                        busy          <= 1'b1;
                    end
                end

                SEND: begin
                    if (m_axis_tready) begin
                        if (i == LAST_IDX) begin
                            state         <= WAIT;
                            i             <= '0;
                            seq           <= seq + 32'd1;
                            cnt           <= CNT_LOAD;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tdata  <= '0;
                            busy          <= 1'b0;
                        end else begin
                            i            <= i_nxt;
                            m_axis_tdata <= byte_at(i_nxt, seq);
                            m_axis_tlast <= (i_nxt == LAST_IDX);
                        end
                    end
                end

                WAIT: begin
                    if (cnt == '0) begin
                        if (enable) begin
                            state         <= SEND;
                            i             <= '0;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tdata  <= byte_at('0, seq);
                            busy          <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_gen.sv
// tb_eth_frame_gen
// Directed sequence with random tready stalls against two generator
// instances: the default-length frame (PAYLOAD_LEN=46, N=60) and a long
// frame (PAYLOAD_LEN=300) used for the sequence-number wrap case.
module tb_eth_frame_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en0, en1, rdy0, rdy1;
    logic [7:0]  td0, td1;
    logic        tv0, tv1, tl0, tl1, tu0, tu1, bz0, bz1;
    logic [31:0] fc0, fc1;

    int sel;
    int tests = 0;
    int fails = 0;

    logic [7:0]  td;
    logic        tv, tl, tu, bz;
    logic [31:0] fc;

    always #5 clk = ~clk;

    eth_frame_gen #(.PAYLOAD_LEN(46), .INTERVAL(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(en0),
        .m_axis_tdata(td0), .m_axis_tvalid(tv0), .m_axis_tready(rdy0),
        .m_axis_tlast(tl0), .m_axis_tuser(tu0),
        .frame_count(fc0), .busy(bz0)
    );

    eth_frame_gen #(.PAYLOAD_LEN(300), .INTERVAL(4)) dut_long (
        .clk(clk), .rst_n(rst_n), .enable(en1),
        .m_axis_tdata(td1), .m_axis_tvalid(tv1), .m_axis_tready(rdy1),
        .m_axis_tlast(tl1), .m_axis_tuser(tu1),
        .frame_count(fc1), .busy(bz1)
    );

    assign td = (sel == 1) ? td1 : td0;
    assign tv = (sel == 1) ? tv1 : tv0;
    assign tl = (sel == 1) ? tl1 : tl0;
    assign tu = (sel == 1) ? tu1 : tu0;
    assign bz = (sel == 1) ? bz1 : bz0;
    assign fc = (sel == 1) ? fc1 : fc0;

    // Reference frame: the 18 header bytes as one big-endian vector, then
    // the payload pattern (index - 18) mod 256.
    function automatic logic [7:0] model_byte(input int idx, input logic [31:0] s);
        logic [143:0] hdr;
        hdr = {48'hFFFF_FFFF_FFFF, 48'h02_00_00_00_00_01, 16'h88B5, s};
        if (idx < 18) return hdr[143 - 8*idx -: 8];
        return 8'((idx - 18) % 256);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_sel(input int s);
        sel = s;
        #1;
    endtask

    task automatic set_enable(input int s, input logic v);
        if (s == 1) en1 = v; else en0 = v;
    endtask

    task automatic set_ready(input int s, input logic v);
        if (s == 1) rdy1 = v; else rdy0 = v;
    endtask

    // Called at a negedge. Follows one frame byte by byte, comparing against
    // the model, checking hold-stability during stalls and that tvalid never
    // drops. Returns at the posedge of the tlast handshake, or at the posedge
    // where reset was applied when abort_at >= 0.
    task automatic capture(input string tag, input int s, input int plen,
                           input logic [31:0] seqv, input bit stall,
                           input int dis_at, input int abort_at);
        int n, idx, cyc;
        bit rdy, held, done;
        logic [7:0] pd;
        logic pl;
        n = 14 + plen; idx = 0; cyc = 0; held = 0; done = 0; pd = '0; pl = 1'b0;
        set_sel(s);
        while (tv !== 1'b1 && cyc < 64) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_start_valid"}, 32'(tv), 32'd1);
        if (tv !== 1'b1) return;
        chk({tag, "_busy"}, 32'(bz), 32'd1);
        chk({tag, "_tuser"}, 32'(tu), 32'd0);
        cyc = 0;
        while (!done) begin
            if (cyc >= 32 * n) begin
                chk({tag, "_timeout_idx"}, 32'(idx), 32'(n));
                set_ready(s, 1'b1);
                return;
            end
            if (abort_at >= 0 && idx == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk);
                return;
            end
            chk($sformatf("%s_valid[%0d]", tag, idx), 32'(tv), 32'd1);
            if (held) begin
                chk($sformatf("%s_hold_data[%0d]", tag, idx), 32'(td), 32'(pd));
                chk($sformatf("%s_hold_last[%0d]", tag, idx), 32'(tl), 32'(pl));
            end
            chk($sformatf("%s_data[%0d]", tag, idx), 32'(td), 32'(model_byte(idx, seqv)));
            chk($sformatf("%s_last[%0d]", tag, idx), 32'(tl), 32'(idx == n - 1));
            if (idx == dis_at) set_enable(s, 1'b0);
            rdy = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
            set_ready(s, rdy);
            pd = td; pl = tl; held = !rdy;
            @(posedge clk);
            cyc++;
            if (rdy) begin
                if (idx == n - 1) done = 1;
                idx++;
            end
            if (!done) @(negedge clk);
        end
        set_ready(s, 1'b1);
    endtask

    // Called at the first negedge after a tlast handshake.
    task automatic gap_check(input string tag, input int exp);
        int g;
        g = 0;
        while (tv !== 1'b1 && g < 100) begin
            g++;
            @(negedge clk);
        end
        chk(tag, 32'(g), 32'(exp));
    endtask

    initial begin
        int vcnt;
        rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1;
        set_sel(0);
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset values on both instances
        for (int s = 0; s < 2; s++) begin
            set_sel(s);
            chk($sformatf("rst_tvalid%0d", s), 32'(tv), 32'd0);
            chk($sformatf("rst_tlast%0d", s), 32'(tl), 32'd0);
            chk($sformatf("rst_tdata%0d", s), 32'(td), 32'd0);
            chk($sformatf("rst_tuser%0d", s), 32'(tu), 32'd0);
            chk($sformatf("rst_count%0d", s), fc, 32'd0);
            chk($sformatf("rst_busy%0d", s), 32'(bz), 32'd0);
        end
        set_sel(0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_valid", 32'(tv), 32'd0);

        // First frame: one-cycle start latency, then seq 0
        en0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("latency_valid", 32'(tv), 32'd1);
        chk("latency_byte0", 32'(td), 32'hFF);
        capture("f1", 0, 46, 32'd0, 1'b0, -1, -1);
        @(negedge clk);
        chk("f1_count", fc, 32'd1);
        gap_check("gap1", 4);

        // Second frame under random stalls, seq 1
        capture("f2", 0, 46, 32'd1, 1'b1, -1, -1);
        @(negedge clk);
        chk("f2_count", fc, 32'd2);
        gap_check("gap2", 4);

        // Third frame: enable dropped at byte 30, frame still completes
        capture("f3", 0, 46, 32'd2, 1'b0, 30, -1);
        vcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (tv === 1'b1) vcnt++;
        end
        chk("f3_no_more_valid", 32'(vcnt), 32'd0);
        chk("f3_count", fc, 32'd3);
        chk("f3_idle_busy", 32'(bz), 32'd0);

        // Fourth frame aborted by reset at byte 20
        en0 = 1'b1;
        capture("f4", 0, 46, 32'd3, 1'b0, -1, 20);
        @(negedge clk);
        chk("abort_tvalid", 32'(tv), 32'd0);
        chk("abort_tlast", 32'(tl), 32'd0);
        chk("abort_tdata", 32'(td), 32'd0);
        chk("abort_count", fc, 32'd0);
        chk("abort_busy", 32'(bz), 32'd0);
        rst_n = 1'b1;
        capture("f5", 0, 46, 32'd0, 1'b0, -1, -1);
        @(negedge clk);
        chk("f5_count", fc, 32'd1);
        en0 = 1'b0;

        // Long frames: sequence number wrap and pattern wrap at index 274
        set_sel(1);
        dut_long.seq = 32'hFFFF_FFFF;
        en1 = 1'b1;
        capture("l1", 1, 300, 32'hFFFF_FFFF, 1'b0, -1, -1);
        @(negedge clk);
        chk("l1_count_wrap", fc, 32'd0);
        gap_check("gap_l", 4);
        capture("l2", 1, 300, 32'd0, 1'b1, 0, -1);
        @(negedge clk);
        chk("l2_count", fc, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
